alu_multicycle: RTL
===================

# alu_multicycle

Parametrised, registered successor to the single-cycle ALU: executes the existing logic/shift/add/subtract operations in one cycle, adds carry-in arithmetic (ADC/SBC), rotate, and iterative multiply and unsigned/signed divide. Sits in the execute stage behind a valid/ready handshake, so the pipeline can stall on multi-cycle operations and on downstream backpressure.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 8 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width. Derived localparam; not overridable.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: block can accept an operation this cycle.
- `alu_opcode` input `alu_op_t`: operation.
- `data_in1` input WIDTH: operand A.
- `data_in2` input WIDTH: operand B; for shifts, the amount is `data_in2[SHW-1:0]`.
- `carry_in` input 1: C flag in, used by ADC, SBC, and zero-amount shifts.
- `out_valid` output 1: result/flags valid.
- `out_ready` input 1: consumer accepts result.
- `data_out` output WIDTH: registered result.
- `flags_out` output `alu_flags_t`: registered N, Z, C, V.
- `busy` output 1: a MUL or DIV iteration is in progress.

## Operation
- Accept when `in_valid && in_ready`. Operands and `carry_in` are captured on the accept edge.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. A held result does not block acceptance if it is drained in the same cycle.
- States:
  - IDLE: accept a single-cycle op, write the output register, stay in IDLE. Accept MUL/UDIV/SDIV and go to ITER.
  - ITER: one step per cycle, with a counter from 0 to WIDTH-1. On the step where count = WIDTH-1, write the output register and return to IDLE.
- Arithmetic. Internal sum is WIDTH+1 bits.
  - ADD = A+B. ADC = A+B+cin. SUB = A+~B+1. SBC = A+~B+cin.
  - C = carry out of bit WIDTH, so for subtraction C=1 means no borrow.
  - V for ADD/ADC: (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - V for SUB/SBC: (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- Logic (AND/ORR/EOR): C=0, V=0.
- Shifts and rotate, with amount `s`:
  - LSL, LSR, ASR as before. ROR rotates right by `s`.
  - If s≠0: C = last bit shifted out (LSL: A[WIDTH-s]; LSR/ASR: A[s-1]; ROR: R[msb]).
  - If s=0: R = A and C = `carry_in`.
  - V = 0 for all shifts and rotate.
- MUL: shift-add, producing the low WIDTH bits of A×B (signed and unsigned give identical bits). C=0, V=0.
- UDIV: restoring division, truncated quotient.
- SDIV:
  - Divide |A| by |B| unsigned, then negate the quotient if the signs of A and B differ.
  - The quotient truncates toward zero.
  - INT_MIN / -1 yields INT_MIN with no special casing.
- Divide by zero: quotient 0. The iteration still runs the full WIDTH cycles. C=0, V=0.
- N = R[msb] and Z = (R==0) for every op.
- Undefined opcode: R=0, all flags 0 except Z=1, completes in one cycle.
- `data_out`/`flags_out` hold stable while `out_valid && !out_ready`. `out_valid` clears on handshake unless a new result is written on the same edge.

## Timing
- Reset (`rst_n` low at an edge): state=IDLE, counter=0, `out_valid`=0, `data_out`=0, `flags_out`=0, `busy`=0. `in_ready`=1 on the following cycle.
- Reset mid-ITER abandons the operation; no result is ever emitted for it.
- Single-cycle ops:
  - `out_valid` is high in the cycle after the accept edge (latency 1).
  - Throughput is 1 op/cycle with `out_ready` held high.
- MUL/DIV:
  - Accept edge E0. Steps occur on E1..E_WIDTH.
  - `out_valid` rises after E_WIDTH, i.e. latency WIDTH cycles.
  - `busy`=1 and `in_ready`=0 from after E0 until after E_WIDTH.
- `out_valid` is never high during ITER, because acceptance guarantees the output slot was freed.
- Inputs are ignored while `in_ready`=0.

## Structure
- `alu_pkg` additions:
  - `alu_op_t` gains ALU_ADC, ALU_SBC, ALU_ROR, ALU_MUL, ALU_UDIV, ALU_SDIV. Existing encodings are unchanged.
  - `alu_flags_t` is unchanged.
  - New `alu_state_t` {IDLE, ITER}.
  - New function `alu_is_multicycle(alu_op_t)`.
- Sub-module `alu_muldiv_core`:
  - Holds the iterative datapath: accumulator, remainder, quotient, step counter, and sign-fix of the operands and quotient.
  - Handshake to it: `start`, `op`, `a`, `b` in; `done`, `result` out.
- Top level holds the FSM, the single-cycle combinational datapath, the output register and the handshake.

## Test plan
All scenarios use WIDTH=32.
1. ADD 0xFFFFFFFF + 0x1 → `data_out`=0, N0 Z1 C1 V0, `out_valid` one cycle after accept.
2. Carry-in arithmetic:
   - ADC 0x7FFFFFFF + 0 with cin=1 → 0x80000000, N1 V1 C0.
   - SBC 5, 3 with cin=0 → 0x1, C1.
3. Shifts and rotate:
   - ROR 0x80000001 by 1 → 0xC0000000, C1.
   - LSL 0x1234 by 0 with cin=1 → 0x1234, C1.
   - ASR 0x80000000 by 31 → 0xFFFFFFFF, C0.
4. Multiply:
   - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, N1. `out_valid` exactly 32 cycles after accept; `busy`=1 and `in_ready`=0 throughout.
   - MUL 0x10000 × 0x10000 → 0, Z1.
5. Divide:
   - SDIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - SDIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
   - UDIV 5 / 0 → 0, Z1, still 32-cycle latency.
6. Backpressure and reset:
   - Hold `out_ready` low for 5 cycles after an ADD result → `data_out`/flags stable and `in_ready`=0. A new op is accepted in the cycle `out_ready` rises.
   - `rst_n` low at iteration 10 of a UDIV → `out_valid`=0, `busy`=0, `in_ready`=1 next cycle, and no late result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bundle, FSM states and
// the single- vs multi-cycle opcode classifier.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_ORR  = 4'd3,
    ALU_EOR  = 4'd4,
    ALU_LSL  = 4'd5,
    ALU_LSR  = 4'd6,
    ALU_ASR  = 4'd7,
    ALU_ADC  = 4'd8,
    ALU_SBC  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_MUL  = 4'd11,
    ALU_UDIV = 4'd12,
    ALU_SDIV = 4'd13
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } alu_state_t;

  function automatic logic alu_is_multicycle(alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_UDIV) || (op == ALU_SDIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle
// for WIDTH cycles after start; done/result are valid on the final step.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             run_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q;   // product accumulator or partial remainder
  logic [WIDTH-1:0] x_q;     // multiplier or dividend/quotient shift register
  logic [WIDTH-1:0] y_q;     // multiplicand or divisor
  logic             is_mul_q;
  logic             neg_q;
  logic             dz_q;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] x_step;
  logic [WIDTH-1:0] y_step;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  logic             is_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign is_signed = (op == ALU_SDIV);
  assign a_abs     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_abs     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  always_comb begin
    acc_step  = acc_q;
    x_step    = x_q;
    y_step    = y_q;
    rem_shift = {acc_q, x_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, y_q};
    if (is_mul_q) begin
      if (x_q[0]) begin
        acc_step = acc_q + y_q;
      end
      x_step = x_q >> 1;
      y_step = y_q << 1;
    end else if (!trial[WIDTH]) begin
      acc_step = trial[WIDTH-1:0];
      x_step   = {x_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = rem_shift[WIDTH-1:0];
      x_step   = {x_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done = run_q && (cnt_q == SHW'(WIDTH - 1));

  // Divide by zero still runs every step but the quotient is forced to zero.
  always_comb begin
    if (is_mul_q) begin
      result = acc_step;
    end else if (dz_q) begin
      result = '0;
    end else if (neg_q) begin
      result = ~x_step + 1'b1;
    end else begin
      result = x_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      is_mul_q <= (op == ALU_MUL);
      if (op == ALU_MUL) begin
        x_q   <= b;
        y_q   <= a;
        neg_q <= 1'b0;
        dz_q  <= 1'b0;
      end else begin
        x_q   <= a_abs;
        y_q   <= b_abs;
        neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        dz_q  <= (b == '0);
      end
    end else if (run_q) begin
      acc_q <= acc_step;
      x_q   <= x_step;
      y_q   <= y_step;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered execute-stage ALU with valid/ready handshake: single-cycle ops
// complete on the accept edge, MUL/DIV hand off to the iterative core.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          alu_opcode,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output alu_flags_t       flags_out,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  alu_flags_t       flags_q, flags_d;

  logic             accept;
  logic             core_start;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  logic [SHW-1:0]   shamt;
  logic [SHW:0]     lsl_idx;
  logic [WIDTH-1:0] addend;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  alu_flags_t       sc_flags;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == ITER);
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign flags_out = flags_q;

  assign shamt   = data_in2[SHW-1:0];
  assign lsl_idx = (SHW+1)'(WIDTH) - {1'b0, shamt};

  // Subtraction is A + ~B + carry so C reads as "no borrow".
  always_comb begin
    unique case (alu_opcode)
      ALU_SUB: begin addend = ~data_in2; add_cin = 1'b1;     end
      ALU_SBC: begin addend = ~data_in2; add_cin = carry_in; end
      ALU_ADC: begin addend = data_in2;  add_cin = carry_in; end
      default: begin addend = data_in2;  add_cin = 1'b0;     end
    endcase
    sum = {1'b0, data_in1} + {1'b0, addend} + (WIDTH+1)'(add_cin);
  end

  always_comb begin
    sc_res   = '0;
    sc_flags = '0;
    case (alu_opcode)
      ALU_ADD, ALU_ADC: begin
        sc_res     = sum[WIDTH-1:0];
        sc_flags.c = sum[WIDTH];
        sc_flags.v = (data_in1[WIDTH-1] == data_in2[WIDTH-1]) &&
                     (sum[WIDTH-1] != data_in1[WIDTH-1]);
      end
      ALU_SUB, ALU_SBC: begin
        sc_res     = sum[WIDTH-1:0];
        sc_flags.c = sum[WIDTH];
        sc_flags.v = (data_in1[WIDTH-1] != data_in2[WIDTH-1]) &&
                     (sum[WIDTH-1] != data_in1[WIDTH-1]);
      end
      ALU_AND: sc_res = data_in1 & data_in2;
      ALU_ORR: sc_res = data_in1 | data_in2;
      ALU_EOR: sc_res = data_in1 ^ data_in2;
      ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROR: begin
        if (shamt == '0) begin
          sc_res     = data_in1;
          sc_flags.c = carry_in;
        end else begin
          unique case (alu_opcode)
            ALU_LSL: begin
              sc_res     = data_in1 << shamt;
              sc_flags.c = data_in1[lsl_idx[SHW-1:0]];
            end
            ALU_LSR: begin
              sc_res     = data_in1 >> shamt;
              sc_flags.c = data_in1[shamt - SHW'(1)];
            end
            ALU_ASR: begin
              sc_res     = WIDTH'($signed(data_in1) >>> shamt);
              sc_flags.c = data_in1[shamt - SHW'(1)];
            end
            default: begin
              sc_res     = (data_in1 >> shamt) | (data_in1 << lsl_idx);
              sc_flags.c = sc_res[WIDTH-1];
            end
          endcase
        end
      end
      default: sc_res = '0;
    endcase
    sc_flags.n = sc_res[WIDTH-1];
    sc_flags.z = (sc_res == '0);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    data_d      = data_q;
    flags_d     = flags_q;
    core_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_is_multicycle(alu_opcode)) begin
            core_start = 1'b1;
            state_d    = ITER;
          end else begin
            data_d      = sc_res;
            flags_d     = sc_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      ITER: begin
        if (core_done) begin
          data_d      = core_result;
          flags_d     = '0;
          flags_d.n   = core_result[WIDTH-1];
          flags_d.z   = (core_result == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
    end
  end

  alu_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .op    (alu_opcode),
    .a     (data_in1),
    .b     (data_in2),
    .done  (core_done),
    .result(core_result)
  );

endmodule
